// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_EXT  = 2'b00;
  localparam cause_t CAUSE_SOFT = 2'b01;
  localparam cause_t CAUSE_TRAP = 2'b10;

endpackage

// File: rtl/rst_sequencer_if.sv
// Request/status bundle between the reset sequencer (slave) and its requester/consumer (master).
interface rst_sequencer_if #(
  parameter int unsigned N_DOM = 3
);
  import rst_seq_pkg::*;

  logic             soft_rst_req;
  logic             trap;
  logic [N_DOM-1:0] rst_out;
  logic             rst_done;
  logic             busy;
  cause_t           rst_cause;

  modport master (
    output soft_rst_req, trap,
    input  rst_out, rst_done, busy, rst_cause
  );

  modport slave (
    input  soft_rst_req, trap,
    output rst_out, rst_done, busy, rst_cause
  );

endinterface

// File: rtl/rst_sync.sv
// Async-assert, sync-deassert shift register; shifts in 1s once the board reset is released.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync_o,
  output logic sync_pre_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // sync_pre_o is the value the last stage loads on the coming edge
  assign sync_o     = sync_q[SYNC_STAGES-1];
  assign sync_pre_o = sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/rst_sequencer.sv
// Reset manager: synchronises board reset release, then frees N_DOM domains in order after
// a hold delay with a fixed stagger; re-enters reset on soft request or CPU trap.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_DOM        = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned HOLD_CYCLES  = 65535,
  parameter int unsigned STAGE_CYCLES = 256,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TRAP_RST     = 1
) (
  input  logic           clk,
  input  logic           reset,
  rst_sequencer_if.slave bus
);

  localparam int unsigned      STG_W      = $clog2(N_DOM) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic [N_DOM-1:0] rst_out_q, rst_out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  cause_t           cause_q, cause_d;

  logic soft_q, soft_dly_q, trap_q, trap_dly_q;
  logic sync_out, sync_pre;
  logic soft_take, trap_take, rerst, last_stage;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .sync_o     (sync_out),
    .sync_pre_o (sync_pre)
  );

  // Edge detectors run in every state so a held level never re-fires after a re-reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      soft_q     <= 1'b0;
      soft_dly_q <= 1'b0;
      trap_q     <= 1'b0;
      trap_dly_q <= 1'b0;
    end else begin
      soft_q     <= bus.soft_rst_req;
      soft_dly_q <= soft_q;
      trap_q     <= bus.trap;
      trap_dly_q <= trap_q;
    end
  end

  assign soft_take  = soft_q && !soft_dly_q && (state_q != ST_SYNC);
  assign trap_take  = (TRAP_RST != 0) && trap_q && !trap_dly_q && (state_q == ST_RUN);
  assign rerst      = soft_take || trap_take;
  assign last_stage = (stg_q == STG_W'(N_DOM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:    if (sync_pre || sync_out) state_d = ST_HOLD;
      ST_HOLD: begin
        if (rerst)                   state_d = ST_HOLD;
        else if (cnt_q == HOLD_LAST) state_d = (N_DOM == 1) ? ST_RUN : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rerst)                                  state_d = ST_HOLD;
        else if (cnt_q == STAGE_LAST && last_stage) state_d = ST_RUN;
      end
      ST_RUN:     if (rerst) state_d = ST_HOLD;
      default:    state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    stg_d     = stg_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    cause_d   = cause_q;
    busy_d    = (state_d != ST_RUN);
    if (rerst) begin
      cnt_d     = '0;
      stg_d     = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
      cause_d   = trap_take ? CAUSE_TRAP : CAUSE_SOFT;
    end else begin
      case (state_q)
        ST_SYNC: cnt_d = '0;
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b0;
            stg_d        = STG_W'(1);
            cnt_d        = '0;
            done_d       = (N_DOM == 1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            for (int unsigned k = 0; k < N_DOM; k++) begin
              if (stg_q == STG_W'(k)) rst_out_d[k] = 1'b0;
            end
            stg_d  = stg_q + STG_W'(1);
            cnt_d  = '0;
            done_d = last_stage;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      stg_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      cause_q   <= CAUSE_EXT;
    end else begin
      cnt_q     <= cnt_d;
      stg_q     <= stg_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.rst_done  = done_q;
  assign bus.busy      = busy_q;
  assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench: two sequencers (trap enabled / disabled) share clock and board reset;
// stimulus queues the expected output changes, a monitor pops one per observed change.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rst_sequencer_if #(.N_DOM(3)) if0 ();
  rst_sequencer_if #(.N_DOM(3)) if1 ();

  rst_sequencer #(.N_DOM(3), .CNT_W(16), .HOLD_CYCLES(10), .STAGE_CYCLES(4),
                  .SYNC_STAGES(2), .TRAP_RST(1)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  rst_sequencer #(.N_DOM(3), .CNT_W(16), .HOLD_CYCLES(10), .STAGE_CYCLES(4),
                  .SYNC_STAGES(2), .TRAP_RST(0)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    int         at_edge;
    bit         async_f;
    logic [6:0] val;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         total  = 0;
  int         bad    = 0;
  int         edge_n = -1;
  logic [6:0] last0  = 'x;
  logic [6:0] last1  = 'x;

  // Edge 0 is the first rising clk edge with reset low
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) edge_n = -1;
    else       edge_n = edge_n + 1;
  end

  function automatic logic [6:0] pat(input logic [2:0] r, input logic d, input logic b,
                                     input logic [1:0] c);
    return {r, d, b, c};
  endfunction

  task automatic push(input int idx, input int e, input bit a, input logic [6:0] v);
    exp_t x;
    x.at_edge = e;
    x.async_f = a;
    x.val     = v;
    if (idx == 0) q0.push_back(x);
    else          q1.push_back(x);
  endtask

  // Hold starting at edge s: domain falls at s+10, s+14, s+18 (done/busy flip with the last)
  task automatic push_seq(input int idx, input int s, input logic [1:0] c,
                          input bit with_start, input int n_fall);
    if (with_start) push(idx, s, 1'b0, pat(3'b111, 1'b0, 1'b1, c));
    if (n_fall > 0) push(idx, s + 10, 1'b0, pat(3'b110, 1'b0, 1'b1, c));
    if (n_fall > 1) push(idx, s + 14, 1'b0, pat(3'b100, 1'b0, 1'b1, c));
    if (n_fall > 2) push(idx, s + 18, 1'b0, pat(3'b000, 1'b1, 1'b0, c));
  endtask

  task automatic check(input int idx, input logic [6:0] obs, input bit src,
                       inout logic [6:0] last);
    exp_t e;
    bit   empty;
    if (obs !== last) begin
      total++;
      empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        bad++;
        $display("FAIL dut%0d unexpected change: edge=%0d val=%b", idx, edge_n, obs);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        if (e.at_edge != edge_n || e.async_f != src || e.val !== obs) begin
          bad++;
          $display("FAIL dut%0d output change: got edge=%0d async=%0b val=%b, want edge=%0d async=%0b val=%b",
                   idx, edge_n, src, obs, e.at_edge, e.async_f, e.val);
        end
      end
      last = obs;
    end
  endtask

  // Monitor: wakes on every falling clk edge and on reset assertion (made in the high phase)
  initial begin
    bit src;
    forever begin
      @(negedge clk or posedge reset);
      src = clk;
      #1;
      check(0, {if0.rst_out, if0.rst_done, if0.busy, if0.rst_cause}, src, last0);
      check(1, {if1.rst_out, if1.rst_done, if1.busy, if1.rst_cause}, src, last1);
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n < n) begin
      total++;
      bad++;
      $display("FAIL wait_edge timeout: edge=%0d want=%0d", edge_n, n);
    end
  endtask

  task automatic drive(input logic s, input logic t);
    if0.soft_rst_req = s;
    if1.soft_rst_req = s;
    if0.trap         = t;
    if1.trap         = t;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      push(i, -1, 1'b1, pat(3'b111, 1'b0, 1'b1, CAUSE_EXT));
      push_seq(i, 1, CAUSE_EXT, 1'b0, 3);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge=%0d", edge_n);
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0);
    // Board reset and full release sequence
    do_reset();

    // One-cycle soft request registered at edge 30
    wait_edge(29);
    push_seq(0, 31, CAUSE_SOFT, 1'b1, 3);
    push_seq(1, 31, CAUSE_SOFT, 1'b1, 3);
    drive(1'b1, 1'b0);
    wait_edge(30);
    drive(1'b0, 1'b0);

    // Trap held high for 40 cycles: one re-reset on dut0, nothing on dut1
    wait_edge(60);
    push_seq(0, 62, CAUSE_TRAP, 1'b1, 3);
    drive(1'b0, 1'b1);
    wait_edge(100);
    drive(1'b0, 1'b0);

    // Soft and trap rise together: trap wins where enabled
    wait_edge(110);
    push_seq(0, 112, CAUSE_TRAP, 1'b1, 3);
    push_seq(1, 112, CAUSE_SOFT, 1'b1, 3);
    drive(1'b1, 1'b1);
    wait_edge(111);
    drive(1'b0, 1'b0);

    // Board reset between release of domains 1 and 2
    wait_edge(139);
    push_seq(0, 141, CAUSE_SOFT, 1'b1, 2);
    push_seq(1, 141, CAUSE_SOFT, 1'b1, 2);
    drive(1'b1, 1'b0);
    wait_edge(140);
    drive(1'b0, 1'b0);
    wait_edge(156);
    do_reset();

    // Soft request, then a second one while the hold counter is at 7, then a trap in HOLD
    wait_edge(29);
    push_seq(0, 31, CAUSE_SOFT, 1'b1, 0);
    push_seq(1, 31, CAUSE_SOFT, 1'b1, 0);
    drive(1'b1, 1'b0);
    wait_edge(30);
    drive(1'b0, 1'b0);
    wait_edge(37);
    push_seq(0, 39, CAUSE_SOFT, 1'b0, 3);
    push_seq(1, 39, CAUSE_SOFT, 1'b0, 3);
    drive(1'b1, 1'b0);
    wait_edge(38);
    drive(1'b0, 1'b0);
    wait_edge(43);
    drive(1'b0, 1'b1);
    wait_edge(44);
    drive(1'b0, 1'b0);
    wait_edge(70);

    total++;
    if (q0.size() != 0) begin
      bad++;
      $display("FAIL dut0 missing changes: left=%0d want=0 next_edge=%0d", q0.size(), q0[0].at_edge);
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL dut1 missing changes: left=%0d want=0 next_edge=%0d", q1.size(), q1[0].at_edge);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
